// File: rtl/geofence_poly.sv
// Point-in-convex-polygon tester: loads a target and NVERT vertices, angle-sorts them
// about v[0], then tests the target against every edge. Option macro: GEOFENCE_EDGE_EN.
module geofence_poly #(
  parameter int COORD_W = 10,
  parameter int NVERT   = 6,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               valid,
  output logic               is_inside,
  output logic               on_edge
);

  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * COORD_W + 2;

  typedef enum logic [3:0] {
    IDLE, LOAD, SORT_A, SORT_B, SWAP, TEST_P, TEST_Q, TEST_R, DONE
  } state_t;

  state_t state, state_next;

  logic [COORD_W-1:0] xt, yt;
  logic [COORD_W-1:0] vx [NVERT];
  logic [COORD_W-1:0] vy [NVERT];
  logic [IDX_W-1:0]   cnt, idx, idx1, pass_len;
  logic signed [PW-1:0] hold_a, hold_b, prod;
  logic [NVERT-1:0]   s;
`ifdef GEOFENCE_EDGE_EN
  logic [NVERT-1:0]   z;
`else
  logic               zero_seen;
`endif

  logic [COORD_W-1:0] xa, ya, xb, yb;
  logic [COORD_W-1:0] mx_p, mx_s, my_p, my_s;
  logic signed [DW-1:0] diff_x, diff_y;
  logic xfer, swap_req, last_cmp, final_cmp;

  assign in_ready = (state == LOAD);
  assign valid    = (state == DONE);
  assign xfer     = in_ready & in_valid;

  // idx1 wraps only in TEST; during SORT idx never exceeds NVERT-2.
  assign idx1 = (idx == IDX_W'(NVERT - 1)) ? '0 : idx + 1'b1;

  always_comb begin
    xa = '0;
    ya = '0;
    xb = '0;
    yb = '0;
    for (int j = 0; j < NVERT; j++) begin
      if (idx == IDX_W'(j)) begin
        xa = vx[j];
        ya = vy[j];
      end
      if (idx1 == IDX_W'(j)) begin
        xb = vx[j];
        yb = vy[j];
      end
    end
  end

  // Both phases share one multiplier: first product (xa,yb), second (xb,ya),
  // relative to v[0] while sorting and to the target while testing.
  always_comb begin
    mx_p = xa;
    my_p = yb;
    mx_s = vx[0];
    my_s = vy[0];
    if (state == SORT_B || state == TEST_Q) begin
      mx_p = xb;
      my_p = ya;
    end
    if (state == TEST_P || state == TEST_Q) begin
      mx_s = xt;
      my_s = yt;
    end
  end

  assign diff_x = $signed({1'b0, mx_p}) - $signed({1'b0, mx_s});
  assign diff_y = $signed({1'b0, my_p}) - $signed({1'b0, my_s});
  assign prod   = PW'(diff_x) * PW'(diff_y);

  assign swap_req  = (hold_a < prod);
  assign last_cmp  = (idx == pass_len);
  assign final_cmp = last_cmp && (pass_len == IDX_W'(1));

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = LOAD;
      LOAD:    if (xfer && cnt == IDX_W'(NVERT)) state_next = SORT_A;
      SORT_A:  state_next = SORT_B;
      SORT_B:  if (swap_req)       state_next = SWAP;
               else if (final_cmp) state_next = TEST_P;
               else                state_next = SORT_A;
      SWAP:    state_next = final_cmp ? TEST_P : SORT_A;
      TEST_P:  state_next = TEST_Q;
      TEST_Q:  state_next = TEST_R;
      TEST_R:  state_next = (idx == IDX_W'(NVERT - 1)) ? DONE : TEST_P;
      DONE:    state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the vertex buffer is a handful of flops, so it is cleared with the rest of the
  // state; a RAM-based buffer would be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xt       <= '0;
      yt       <= '0;
      cnt      <= '0;
      idx      <= '0;
      pass_len <= '0;
      hold_a   <= '0;
      hold_b   <= '0;
      s        <= '0;
`ifdef GEOFENCE_EDGE_EN
      z        <= '0;
`else
      zero_seen <= 1'b0;
`endif
      for (int j = 0; j < NVERT; j++) begin
        vx[j] <= '0;
        vy[j] <= '0;
      end
    end else begin
      case (state)
        LOAD: if (xfer) begin
          if (cnt == '0) begin
            xt <= X;
            yt <= Y;
          end
          for (int j = 0; j < NVERT; j++) begin
            if (cnt == IDX_W'(j + 1)) begin
              vx[j] <= X;
              vy[j] <= Y;
            end
          end
          if (cnt == IDX_W'(NVERT)) begin
            cnt      <= '0;
            idx      <= IDX_W'(1);
            pass_len <= IDX_W'(NVERT - 2);
`ifndef GEOFENCE_EDGE_EN
            zero_seen <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SORT_A, TEST_P: hold_a <= prod;
        TEST_Q:         hold_b <= prod;
        SORT_B, SWAP: begin
          if (state == SWAP) begin
            for (int j = 0; j < NVERT; j++) begin
              if (idx == IDX_W'(j)) begin
                vx[j] <= xb;
                vy[j] <= yb;
              end
              if (idx1 == IDX_W'(j)) begin
                vx[j] <= xa;
                vy[j] <= ya;
              end
            end
          end
          if (state == SWAP || !swap_req) begin
            if (final_cmp) begin
              idx      <= '0;
              pass_len <= '0;
            end else if (last_cmp) begin
              idx      <= IDX_W'(1);
              pass_len <= pass_len - 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        TEST_R: begin
          for (int j = 0; j < NVERT; j++) begin
            if (idx == IDX_W'(j)) begin
              s[j] <= (hold_a > hold_b);
`ifdef GEOFENCE_EDGE_EN
              z[j] <= (hold_a == hold_b);
`endif
            end
          end
`ifndef GEOFENCE_EDGE_EN
          if (hold_a == hold_b) zero_seen <= 1'b1;
`endif
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef GEOFENCE_EDGE_EN
  // A zero edge has s=0, so "all non-zero edges negative" reduces to no s bit set.
  logic inside_raw;
  assign inside_raw = (&(s | z)) | ~(|s);
  assign is_inside  = valid & inside_raw;
  assign on_edge    = valid & inside_raw & (|z);
`else
  assign is_inside = valid & ~zero_seen & ((&s) | ~(|s));
  assign on_edge   = 1'b0;
`endif

endmodule

// File: tb/tb_geofence_poly.sv
// Directed bench for geofence_poly: hexagon (NVERT=6) and square (NVERT=4) jobs,
// boundary points, handshake gaps, back-to-back jobs and mid-job reset.
module tb_geofence_poly;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] X = '0;
  logic [9:0] Y = '0;
  logic       a_in_valid = 1'b0, b_in_valid = 1'b0;
  logic       a_in_ready, a_valid, a_inside, a_edge;
  logic       b_in_ready, b_valid, b_inside, b_edge;

  int n_checks = 0;
  int n_fail   = 0;
  int a_pulses = 0, b_pulses = 0, a_wide = 0, b_wide = 0;
  logic a_prev = 1'b0, b_prev = 1'b0;

  int hex_x[6] = '{300, 100, 0, 200, 200, 100};
  int hex_y[6] = '{100, 0, 100, 200, 0, 200};
  int sq_x[4]  = '{1023, 0, 1023, 0};
  int sq_y[4]  = '{1023, 0, 0, 1023};

`ifdef GEOFENCE_EDGE_EN
  localparam logic EXP_BND_IN = 1'b1, EXP_BND_ON = 1'b1;
`else
  localparam logic EXP_BND_IN = 1'b0, EXP_BND_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  geofence_poly u_a (
    .clk(clk), .reset(reset), .X(X), .Y(Y), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .valid(a_valid), .is_inside(a_inside), .on_edge(a_edge)
  );

  geofence_poly #(.NVERT(4)) u_b (
    .clk(clk), .reset(reset), .X(X), .Y(Y), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .valid(b_valid), .is_inside(b_inside), .on_edge(b_edge)
  );

  always @(negedge clk) begin
    if (a_valid) a_pulses++;
    if (b_valid) b_pulses++;
    if (a_valid && a_prev) a_wide++;
    if (b_valid && b_prev) b_wide++;
    a_prev = a_valid;
    b_prev = b_valid;
  end

  task automatic push(input int sel, input int x, input int y, input int gap);
    int w;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    X = 10'(x);
    Y = 10'(y);
    if (sel == 0) a_in_valid = 1'b1;
    else          b_in_valid = 1'b1;
    w = 0;
    while (!((sel == 0) ? a_in_ready : b_in_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready never rose (sel=%0d)", sel);
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic send_job(input int sel, input int tx, input int ty, input int max_gap);
    int nv;
    nv = (sel == 0) ? 6 : 4;
    push(sel, tx, ty, (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    for (int i = 0; i < nv; i++) begin
      if (sel == 0) push(sel, hex_x[i], hex_y[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
      else          push(sel, sq_x[i], sq_y[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    end
  endtask

  // Waits for valid; optionally holds in_valid high to show it is ignored while busy.
  task automatic wait_result(input int sel, input logic hold, output logic ins,
                             output logic edg, output int lat, output logic ready_seen);
    logic got;
    got = 1'b0;
    lat = 0;
    ins = 1'b0;
    edg = 1'b0;
    ready_seen = 1'b0;
    if (hold) begin
      X = 10'd7;
      Y = 10'd9;
      if (sel == 0) a_in_valid = 1'b1;
      else          b_in_valid = 1'b1;
    end
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if ((sel == 0) ? a_valid : b_valid) begin
        got = 1'b1;
        ins = (sel == 0) ? a_inside : b_inside;
        edg = (sel == 0) ? a_edge : b_edge;
      end else if ((sel == 0) ? a_in_ready : b_in_ready) begin
        ready_seen = 1'b1;
      end
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: no valid within %0d cycles (sel=%0d)", lat, sel);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", a_in_ready); end
    n_checks++; if (a_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_valid got=%b exp=0", a_valid); end
    n_checks++; if (a_inside !== 1'b0)   begin n_fail++; $display("FAIL rst_inside got=%b exp=0", a_inside); end
    n_checks++; if (a_edge !== 1'b0)     begin n_fail++; $display("FAIL rst_edge got=%b exp=0", a_edge); end
    reset = 1'b1;
    #1;
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready got=%b exp=0", a_in_ready); end
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL load_in_ready got=%b exp=1", a_in_ready); end
  endtask

  task automatic test_inside;
    logic ins, edg, rs;
    int lat, p0;
    p0 = a_pulses;
    send_job(0, 150, 100, 0);
    wait_result(0, 1'b0, ins, edg, lat, rs);
    n_checks++; if (ins !== 1'b1) begin n_fail++; $display("FAIL t1_inside got=%b exp=1", ins); end
    n_checks++; if (lat > 60)     begin n_fail++; $display("FAIL t1_latency got=%0d exp<=60", lat); end
    @(negedge clk);
    n_checks++; if (a_pulses !== p0 + 1) begin n_fail++; $display("FAIL t1_pulses got=%0d exp=%0d", a_pulses - p0, 1); end
  endtask

  task automatic test_outside;
    logic ins, edg, rs;
    int lat;
    send_job(0, 350, 100, 0);
    wait_result(0, 1'b0, ins, edg, lat, rs);
    n_checks++; if (ins !== 1'b0) begin n_fail++; $display("FAIL t2_inside got=%b exp=0", ins); end
  endtask

  task automatic test_boundary;
    logic ins, edg, rs;
    int lat;
    send_job(0, 150, 0, 0);
    wait_result(0, 1'b0, ins, edg, lat, rs);
    n_checks++; if (ins !== EXP_BND_IN) begin n_fail++; $display("FAIL t3_inside got=%b exp=%b", ins, EXP_BND_IN); end
    n_checks++; if (edg !== EXP_BND_ON) begin n_fail++; $display("FAIL t3_on_edge got=%b exp=%b", edg, EXP_BND_ON); end
  endtask

  task automatic test_square;
    logic ins, edg, rs;
    int lat;
    send_job(1, 512, 512, 0);
    wait_result(1, 1'b0, ins, edg, lat, rs);
    n_checks++; if (ins !== 1'b1) begin n_fail++; $display("FAIL t4_center_inside got=%b exp=1", ins); end
    n_checks++; if (edg !== 1'b0) begin n_fail++; $display("FAIL t4_center_edge got=%b exp=0", edg); end
    send_job(1, 1024, 1024, 0);  // masks to (0,0), a corner vertex
    wait_result(1, 1'b0, ins, edg, lat, rs);
    n_checks++; if (ins !== EXP_BND_IN) begin n_fail++; $display("FAIL t4_corner_inside got=%b exp=%b", ins, EXP_BND_IN); end
    n_checks++; if (edg !== EXP_BND_ON) begin n_fail++; $display("FAIL t4_corner_edge got=%b exp=%b", edg, EXP_BND_ON); end
  endtask

  task automatic test_back_to_back;
    logic ins1, ins2, edg, rs1, rs2;
    int lat;
    send_job(0, 150, 100, 5);
    wait_result(0, 1'b1, ins1, edg, lat, rs1);
    send_job(0, 350, 100, 0);
    wait_result(0, 1'b1, ins2, edg, lat, rs2);
    n_checks++; if (ins1 !== 1'b1) begin n_fail++; $display("FAIL t5_job1_inside got=%b exp=1", ins1); end
    n_checks++; if (ins2 !== 1'b0) begin n_fail++; $display("FAIL t5_job2_inside got=%b exp=0", ins2); end
    n_checks++; if (rs1 !== 1'b0)  begin n_fail++; $display("FAIL t5_busy_ready got=%b exp=0", rs1); end
  endtask

  task automatic test_abort;
    logic ins, edg, rs;
    int lat, p0;
    send_job(0, 150, 100, 0);
    repeat (5) @(negedge clk);
    p0 = a_pulses;
    reset = 1'b0;
    #1;
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL t6_rst_ready got=%b exp=0", a_in_ready); end
    n_checks++; if (a_valid !== 1'b0)    begin n_fail++; $display("FAIL t6_rst_valid got=%b exp=0", a_valid); end
    @(negedge clk);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    n_checks++; if (a_pulses !== p0) begin n_fail++; $display("FAIL t6_aborted_pulse got=%0d exp=%0d", a_pulses, p0); end
    send_job(0, 150, 100, 0);
    wait_result(0, 1'b0, ins, edg, lat, rs);
    n_checks++; if (ins !== 1'b1) begin n_fail++; $display("FAIL t6_fresh_inside got=%b exp=1", ins); end
  endtask

  initial begin
    test_reset();
    test_inside();
    test_outside();
    test_boundary();
    test_square();
    test_back_to_back();
    test_abort();
    repeat (2) @(negedge clk);
    n_checks++; if (a_wide !== 0) begin n_fail++; $display("FAIL valid_width_a got=%0d exp=0", a_wide); end
    n_checks++; if (b_wide !== 0) begin n_fail++; $display("FAIL valid_width_b got=%0d exp=0", b_wide); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
